// File: rtl/apb_irq_ctrl.sv
// Purpose : APB slave interrupt controller that shares one CPU irq line among SRC_NUM edge-triggered sources,
//           with per-source pending/enable/priority, a global threshold and a claim/complete handshake.
// Latency : source edge -> irq_o in 2 cycles (4 cycles when IRQC_SYNC_EN is defined); APB zero wait states.
// Backpr. : none; pready is tied high and every access completes in its access-phase cycle.
//
// Optional build macro: IRQC_SYNC_EN adds a 2-flop synchronizer on irq_src_i ahead of edge detection.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   paddr/pwdata/pwrite APB address (only [7:0] decoded), write data, write strobe
//   psel/penable        APB select / access phase
//   prdata/pready       APB read data (combinational in access phase), ready (always 1)
//   pslverr             1 on unmapped address during the access phase
//   irq_src_i           raw active-high edge-triggered sources; bit i-1 is source ID i
//   irq_o               registered interrupt request to the CPU
//
// Register map (paddr[7:0]): 0x00 PENDING RO, 0x04 ENABLE RW, 0x08 THRESHOLD RW,
//   0x0C CLAIM (read) / COMPLETE (write), 0x10+4*(i-1) PRIO[i] RW.
module apb_irq_ctrl #(
  parameter int SRC_NUM = 4,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        paddr,
  input  logic [31:0]        pwdata,
  input  logic               pwrite,
  input  logic               psel,
  input  logic               penable,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic [SRC_NUM-1:0] irq_src_i,
  output logic               irq_o
);

  localparam logic [7:0] ADDR_PENDING = 8'h00;
  localparam logic [7:0] ADDR_ENABLE  = 8'h04;
  localparam logic [7:0] ADDR_THRESH  = 8'h08;
  localparam logic [7:0] ADDR_CLAIM   = 8'h0C;
  localparam logic [7:0] ADDR_PRIO0   = 8'h10;

  // State; source ID i lives at bit/index i, ID 0 means "none".
  logic [SRC_NUM:1]  pending;
  logic [SRC_NUM:1]  enable;
  logic [SRC_NUM:1]  in_service;
  logic [PRIO_W-1:0] threshold;
  logic [PRIO_W-1:0] prio [1:SRC_NUM];

  logic [SRC_NUM-1:0] src_s;
  logic [SRC_NUM-1:0] src_d;
  logic [SRC_NUM:1]   edge_mask;

  logic [SRC_NUM:1]  eligible;
  logic [4:0]        win_id;
  logic [PRIO_W-1:0] win_prio;

  logic [SRC_NUM:1]  claim_mask;
  logic [SRC_NUM:1]  complete_mask;

  logic [7:0]  addr;
  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  prio_off;
  logic [5:0]  prio_sel;
  logic        prio_hit;
  logic [31:0] rdata;
  logic        mapped;

  logic unused_bits;
  assign unused_bits = ^{paddr[31:8], pwdata};

  assign addr   = paddr[7:0];
  assign access = psel & penable;
  assign wr_en  = access & pwrite;
  assign rd_en  = access & ~pwrite;

  // PRIO window: word-aligned offsets from 0x10, one word per source.
  assign prio_off = addr - ADDR_PRIO0;
  assign prio_sel = prio_off[7:2];
  assign prio_hit = (addr >= ADDR_PRIO0) && (addr[1:0] == 2'b00) && (prio_sel < 6'(SRC_NUM));

  // ---------------- source conditioning / gateway ----------------
`ifdef IRQC_SYNC_EN
  logic [SRC_NUM-1:0] sync_q1;
  logic [SRC_NUM-1:0] sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src_i;
      sync_q2 <= sync_q1;
    end
  end

  assign src_s = sync_q2;
`else
  assign src_s = irq_src_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_d <= '0;
    end else begin
      src_d <= src_s;
    end
  end

  // Bit i-1 of the source bus maps to ID i by position.
  assign edge_mask = src_s & ~src_d;

  // ---------------- arbiter ----------------
  // Strict '>' while scanning upward keeps the lowest ID on equal priority.
  // Eligible sources always have prio > threshold >= 0, so win_prio = 0 is a safe seed.
  always_comb begin
    eligible = '0;
    win_id   = '0;
    win_prio = '0;
    for (int i = 1; i <= SRC_NUM; i++) begin
      eligible[i] = pending[i] & enable[i] & ~in_service[i] & (prio[i] > threshold);
      if (eligible[i] && (prio[i] > win_prio)) begin
        win_id   = 5'(i);
        win_prio = prio[i];
      end
    end
  end

  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int i = 1; i <= SRC_NUM; i++) begin
      claim_mask[i]    = rd_en && (addr == ADDR_CLAIM) && (win_id == 5'(i));
      complete_mask[i] = wr_en && (addr == ADDR_CLAIM) && (pwdata[4:0] == 5'(i));
    end
  end

  // ---------------- state update ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      enable     <= '0;
      in_service <= '0;
      threshold  <= '0;
      irq_o      <= 1'b0;
      for (int i = 1; i <= SRC_NUM; i++) begin
        prio[i] <= '0;
      end
    end else begin
      // A fresh edge outranks a same-cycle claim so the new event is not lost.
      pending    <= (pending & ~claim_mask) | edge_mask;
      // Claim and complete never coincide: both use the single APB access slot.
      in_service <= (in_service | claim_mask) & ~complete_mask;
      irq_o      <= |eligible;

      if (wr_en && (addr == ADDR_ENABLE)) begin
        enable <= pwdata[SRC_NUM:1];
      end
      if (wr_en && (addr == ADDR_THRESH)) begin
        threshold <= pwdata[PRIO_W-1:0];
      end
      for (int i = 1; i <= SRC_NUM; i++) begin
        if (wr_en && prio_hit && (prio_sel == 6'(i - 1))) begin
          prio[i] <= pwdata[PRIO_W-1:0];
        end
      end
    end
  end

  // ---------------- APB read path ----------------
  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (addr)
      ADDR_PENDING: rdata = 32'({pending, 1'b0});
      ADDR_ENABLE:  rdata = 32'({enable, 1'b0});
      ADDR_THRESH:  rdata = 32'(threshold);
      ADDR_CLAIM:   rdata = 32'(win_id);
      default: begin
        if (prio_hit) begin
          for (int i = 1; i <= SRC_NUM; i++) begin
            if (prio_sel == 6'(i - 1)) begin
              rdata = 32'(prio[i]);
            end
          end
        end else begin
          mapped = 1'b0;
        end
      end
    endcase
  end

  assign prdata  = access ? rdata : 32'h0;
  assign pslverr = access & ~mapped;
  assign pready  = 1'b1;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Purpose : directed self-checking bench for apb_irq_ctrl (SRC_NUM=4, PRIO_W=3).
// Latency : expects edge->irq_o of 2 cycles, or 4 when IRQC_SYNC_EN is defined.
// Backpr. : APB tasks assume zero wait states (pready is also checked).
module tb_apb_irq_ctrl;

`ifdef IRQC_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [3:0]  irq_src;
  logic        irq_o;

  int n_vec;
  int n_err;

  apb_irq_ctrl #(.SRC_NUM(4), .PRIO_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pwrite    (pwrite),
    .psel      (psel),
    .penable   (penable),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .irq_src_i (irq_src),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    paddr = {24'h0, a}; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    paddr = {24'h0, a}; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    d = prdata;
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(a, d, e);
    chk(tag, d, exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // One-cycle pulse on the given source bits, then let the pipeline settle.
  task automatic pulse(input logic [3:0] mask, input int settle);
    @(posedge clk); #1;
    irq_src = mask;
    @(posedge clk); #1;
    irq_src = 4'h0;
    idle(settle);
  endtask

  // Pulse and count cycles until irq_o rises; bounded so a dead irq_o just reports 0.
  task automatic meas_lat(input string tag, input logic [3:0] mask);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    irq_src = mask;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) irq_src = 4'h0;
      if (irq_o && (lat == 0)) lat = c;
    end
    chk(tag, 32'(lat), 32'(LAT));
  endtask

  task automatic all_regs_zero(input string tag);
    logic [7:0] addrs [8];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    for (int k = 0; k < 8; k++) begin
      rd_chk($sformatf("%s_%02h", tag, addrs[k]), addrs[k], 32'h0);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
    irq_src = 4'h0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // --- reset state ---
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_prdata_idle", prdata, 32'h0);
    chk("pready", 32'(pready), 32'h1);
    all_regs_zero("rst_reg");
    apb_read(8'h80, d, e);
    chk("unmapped_prdata", d, 32'h0);
    chk("unmapped_pslverr", 32'(e), 32'h1);
    apb_read(8'h08, d, e);
    chk("mapped_pslverr", 32'(e), 32'h0);

    // --- single source, measured latency, claim ---
    apb_write(8'h14, 32'd3);
    apb_write(8'h04, 32'h04);
    apb_write(8'h08, 32'd0);
    rd_chk("prio2_rb", 8'h14, 32'd3);
    rd_chk("enable_rb", 8'h04, 32'h04);
    meas_lat("lat_src2", 4'b0010);
    rd_chk("claim_2", 8'h0C, 32'd2);
    idle(1);
    chk("irq_after_claim", 32'(irq_o), 32'h0);
    rd_chk("pend_after_claim", 8'h00, 32'h0);
    apb_write(8'h0C, 32'd2);

    // --- priority ordering with tie ---
    apb_write(8'h10, 32'd5);
    apb_write(8'h14, 32'd7);
    apb_write(8'h18, 32'd5);
    apb_write(8'h04, 32'h0E);
    pulse(4'b0111, 5);
    rd_chk("pend_three", 8'h00, 32'h0E);
    chk("irq_three", 32'(irq_o), 32'h1);
    rd_chk("claim_first", 8'h0C, 32'd2);
    rd_chk("claim_second", 8'h0C, 32'd1);
    rd_chk("claim_third", 8'h0C, 32'd3);
    rd_chk("claim_none", 8'h0C, 32'd0);
    apb_write(8'h0C, 32'd1);
    apb_write(8'h0C, 32'd2);
    apb_write(8'h0C, 32'd3);

    // --- threshold masking ---
    apb_write(8'h10, 32'd2);
    apb_write(8'h08, 32'd2);
    pulse(4'b0001, 5);
    rd_chk("pend_thr", 8'h00, 32'h02);
    chk("irq_thr_masked", 32'(irq_o), 32'h0);
    apb_write(8'h08, 32'd1);
    chk("irq_thr_same_cyc", 32'(irq_o), 32'h0);
    idle(1);
    chk("irq_thr_lowered", 32'(irq_o), 32'h1);

    // --- in-service exclusion and complete ---
    rd_chk("claim_1", 8'h0C, 32'd1);
    pulse(4'b0001, 5);
    rd_chk("pend_in_svc", 8'h00, 32'h02);
    chk("irq_in_svc", 32'(irq_o), 32'h0);
    apb_write(8'h0C, 32'd5);
    idle(1);
    chk("irq_bogus_cmpl", 32'(irq_o), 32'h0);
    apb_write(8'h0C, 32'd1);
    chk("irq_cmpl_same_cyc", 32'(irq_o), 32'h0);
    idle(1);
    chk("irq_cmpl", 32'(irq_o), 32'h1);

    // --- disabling keeps pending, drops irq next cycle ---
    apb_write(8'h04, 32'h00);
    idle(1);
    chk("irq_disabled", 32'(irq_o), 32'h0);
    rd_chk("pend_disabled", 8'h00, 32'h02);

    // --- asynchronous reset with pending/in_service set ---
    apb_write(8'h14, 32'd4);
    apb_write(8'h04, 32'h06);
    rd_chk("claim_1_again", 8'h0C, 32'd1);
    pulse(4'b0011, 5);
    rd_chk("pend_pre_rst", 8'h00, 32'h06);
    chk("irq_pre_rst", 32'(irq_o), 32'h1);
    #1;
    rst_n = 1'b0;
    #2;
    chk("irq_async_rst", 32'(irq_o), 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    all_regs_zero("post_rst");

    // --- latency after reset ---
    apb_write(8'h10, 32'd1);
    apb_write(8'h04, 32'h02);
    meas_lat("lat_src1", 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
